// File: rtl/spio_uart_pkt_rx.sv
// UART byte stream to 72-bit SpiNNaker packet framer: SOF hunt, XOR checksum, inter-byte timeout.
// Packet valid one cycle after the checksum byte; byte input is stalled while a packet waits downstream.
module spio_uart_pkt_rx #(
    parameter logic [7:0] SOF_BYTE       = 8'h7E,
    parameter int         TIMEOUT_BITS   = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [7:0]  BYTE_DATA_IN,
    input  logic        BYTE_VLD_IN,
    output logic        BYTE_RDY_OUT,
    output logic [71:0] PKT_DATA_OUT,
    output logic        PKT_VLD_OUT,
    input  logic        PKT_RDY_IN,
    output logic        CSUM_ERR_OUT,
    output logic        TIMEOUT_OUT,
    output logic        JUNK_OUT
);

    typedef enum logic [2:0] {
        HUNT,
        CTRL,
        KEY,
        PLD,
        CSUM,
        EMIT
    } state_t;

    localparam bit                      TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TIMEOUT_BITS'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_BITS-1:0] TO_MAX  = {TIMEOUT_BITS{1'b1}};

    state_t                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [71:0]             pkt_q, pkt_d;
    logic                    vld_q, vld_d;
    logic [TIMEOUT_BITS-1:0] cnt_q, cnt_d;
    logic                    csum_err_q, csum_err_d;
    logic                    timeout_q, timeout_d;
    logic                    junk_q, junk_d;
    logic                    xfer;
    logic                    in_frame;

    assign BYTE_RDY_OUT = !RESET_IN && (state_q != EMIT);
    assign xfer         = BYTE_VLD_IN && BYTE_RDY_OUT;
    assign in_frame     = (state_q == CTRL) || (state_q == KEY) ||
                          (state_q == PLD)  || (state_q == CSUM);

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q    <= HUNT;
            idx_q      <= 2'd0;
            csum_q     <= 8'd0;
            pkt_q      <= 72'd0;
            vld_q      <= 1'b0;
            cnt_q      <= '0;
            csum_err_q <= 1'b0;
            timeout_q  <= 1'b0;
            junk_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            pkt_q      <= pkt_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
            csum_err_q <= csum_err_d;
            timeout_q  <= timeout_d;
            junk_q     <= junk_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        pkt_d      = pkt_q;
        vld_d      = vld_q;
        cnt_d      = '0;
        csum_err_d = 1'b0;
        timeout_d  = 1'b0;
        junk_d     = 1'b0;

        // Idle counter saturates so a disabled timeout can never wrap into a false expiry.
        if (in_frame && !xfer && (cnt_q != TO_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (in_frame && !xfer) begin
            cnt_d = cnt_q;
        end

        case (state_q)
            HUNT: begin
                if (xfer) begin
                    if (BYTE_DATA_IN == SOF_BYTE) begin
                        state_d = CTRL;
                        csum_d  = 8'd0;
                    end else begin
                        junk_d = 1'b1;
                    end
                end
            end
            CTRL: begin
                if (xfer) begin
                    pkt_d[7:0] = BYTE_DATA_IN;
                    csum_d     = csum_q ^ BYTE_DATA_IN;
                    idx_d      = 2'd0;
                    state_d    = KEY;
                end
            end
            KEY: begin
                if (xfer) begin
                    pkt_d[8 + 8*idx_q +: 8] = BYTE_DATA_IN;
                    csum_d = csum_q ^ BYTE_DATA_IN;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (pkt_q[1]) begin
                            state_d = PLD;
                        end else begin
                            state_d      = CSUM;
                            pkt_d[71:40] = 32'd0;
                        end
                    end
                end
            end
            PLD: begin
                if (xfer) begin
                    pkt_d[40 + 8*idx_q +: 8] = BYTE_DATA_IN;
                    csum_d = csum_q ^ BYTE_DATA_IN;
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    if (BYTE_DATA_IN == csum_q) begin
                        state_d = EMIT;
                        vld_d   = 1'b1;
                    end else begin
                        state_d    = HUNT;
                        csum_err_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (PKT_RDY_IN && vld_q) begin
                    state_d = HUNT;
                    vld_d   = 1'b0;
                end
            end
            default: begin
                state_d = HUNT;
                vld_d   = 1'b0;
            end
        endcase

        // A byte landing in the expiry cycle wins; expiry only acts on an idle cycle.
        if (TO_EN && in_frame && !xfer && (cnt_q == TO_LAST)) begin
            state_d   = HUNT;
            timeout_d = 1'b1;
            cnt_d     = '0;
        end
    end

    assign PKT_DATA_OUT = pkt_q;
    assign PKT_VLD_OUT  = vld_q;
    assign CSUM_ERR_OUT = csum_err_q;
    assign TIMEOUT_OUT  = timeout_q;
    assign JUNK_OUT     = junk_q;

endmodule

// File: tb/tb_spio_uart_pkt_rx.sv
// Randomised and directed frame stimulus; a scoreboard monitor checks packets, pulse counts and handshake rules.
module tb_spio_uart_pkt_rx;

    logic        CLK_IN       = 1'b0;
    logic        RESET_IN     = 1'b1;
    logic [7:0]  BYTE_DATA_IN = 8'd0;
    logic        BYTE_VLD_IN  = 1'b0;
    logic        BYTE_RDY_OUT;
    logic [71:0] PKT_DATA_OUT;
    logic        PKT_VLD_OUT;
    logic        PKT_RDY_IN   = 1'b1;
    logic        CSUM_ERR_OUT;
    logic        TIMEOUT_OUT;
    logic        JUNK_OUT;

    spio_uart_pkt_rx #(
        .SOF_BYTE       (8'h7E),
        .TIMEOUT_BITS   (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK_IN       (CLK_IN),
        .RESET_IN     (RESET_IN),
        .BYTE_DATA_IN (BYTE_DATA_IN),
        .BYTE_VLD_IN  (BYTE_VLD_IN),
        .BYTE_RDY_OUT (BYTE_RDY_OUT),
        .PKT_DATA_OUT (PKT_DATA_OUT),
        .PKT_VLD_OUT  (PKT_VLD_OUT),
        .PKT_RDY_IN   (PKT_RDY_IN),
        .CSUM_ERR_OUT (CSUM_ERR_OUT),
        .TIMEOUT_OUT  (TIMEOUT_OUT),
        .JUNK_OUT     (JUNK_OUT)
    );

    // kind: 0 checkpoint of counts, 1 reset values, 2 packet valid now, 3 byte stall
    typedef struct {
        int kind;
        int tag;
        int e_csum;
        int e_to;
        int e_junk;
    } req_t;

    logic [71:0] exp_q[$];
    req_t        req_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int got_csum = 0;
    int got_to   = 0;
    int got_junk = 0;
    int exp_csum = 0;
    int exp_to   = 0;
    int exp_junk = 0;
    bit hold_low = 1'b0;
    bit rnd_bp   = 1'b0;
    int gap_max  = 0;

    initial forever #5 CLK_IN = ~CLK_IN;

    initial forever begin
        @(posedge CLK_IN);
        #1;
        PKT_RDY_IN = hold_low ? 1'b0 : (rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] model_pkt(input logic [7:0] c, input logic [31:0] k,
                                              input logic [31:0] p);
        return {(c[1] ? p : 32'd0), k, c};
    endfunction

    function automatic logic [7:0] model_csum(input logic [7:0] c, input logic [31:0] k,
                                              input logic [31:0] p);
        logic [7:0] s;
        s = c;
        for (int i = 0; i < 4; i++) begin
            s = s ^ k[8*i +: 8];
            if (c[1]) s = s ^ p[8*i +: 8];
        end
        return s;
    endfunction

    // Monitor / scoreboard
    initial begin
        logic        prev_vld;
        logic        prev_hs;
        logic [71:0] prev_dat;
        logic [71:0] e;
        req_t        r;
        prev_vld = 1'b0;
        prev_hs  = 1'b0;
        prev_dat = 72'd0;
        forever begin
            @(negedge CLK_IN);
            if (RESET_IN) begin
                prev_vld = 1'b0;
                prev_hs  = 1'b0;
            end else begin
                n_tests++;
                if (BYTE_RDY_OUT !== ~PKT_VLD_OUT) begin
                    n_fail++;
                    $display("FAIL rdy_vs_vld: BYTE_RDY_OUT=%b with PKT_VLD_OUT=%b, required inverse",
                             BYTE_RDY_OUT, PKT_VLD_OUT);
                end
                if (PKT_VLD_OUT === 1'b1 && prev_vld && !prev_hs) begin
                    n_tests++;
                    if (PKT_DATA_OUT !== prev_dat) begin
                        n_fail++;
                        $display("FAIL hold_stable: data=%h required %h", PKT_DATA_OUT, prev_dat);
                    end
                end
                if (PKT_VLD_OUT === 1'b1 && PKT_RDY_IN === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_pkt: data=%h required none", PKT_DATA_OUT);
                    end else begin
                        e = exp_q.pop_front();
                        if (PKT_DATA_OUT !== e) begin
                            n_fail++;
                            $display("FAIL pkt_data: data=%h required %h", PKT_DATA_OUT, e);
                        end
                    end
                end
                if (CSUM_ERR_OUT === 1'b1) got_csum++;
                if (TIMEOUT_OUT === 1'b1)  got_to++;
                if (JUNK_OUT === 1'b1)     got_junk++;
                prev_vld = (PKT_VLD_OUT === 1'b1);
                prev_hs  = (PKT_VLD_OUT === 1'b1) && (PKT_RDY_IN === 1'b1);
                prev_dat = PKT_DATA_OUT;
            end
            while (req_q.size() > 0) begin
                r = req_q.pop_front();
                case (r.kind)
                    0: begin
                        n_tests += 4;
                        if (got_csum != r.e_csum) begin
                            n_fail++;
                            $display("FAIL csum_err_count[%0d]: got %0d required %0d", r.tag, got_csum, r.e_csum);
                        end
                        if (got_to != r.e_to) begin
                            n_fail++;
                            $display("FAIL timeout_count[%0d]: got %0d required %0d", r.tag, got_to, r.e_to);
                        end
                        if (got_junk != r.e_junk) begin
                            n_fail++;
                            $display("FAIL junk_count[%0d]: got %0d required %0d", r.tag, got_junk, r.e_junk);
                        end
                        if (exp_q.size() != 0) begin
                            n_fail++;
                            $display("FAIL pkt_pending[%0d]: %0d packets missing, required 0", r.tag, exp_q.size());
                        end
                    end
                    1: begin
                        n_tests += 2;
                        if ({PKT_VLD_OUT, CSUM_ERR_OUT, TIMEOUT_OUT, JUNK_OUT, BYTE_RDY_OUT} !== 5'b0) begin
                            n_fail++;
                            $display("FAIL reset_ctrl[%0d]: vld,cerr,to,junk,rdy=%b required 00000", r.tag,
                                     {PKT_VLD_OUT, CSUM_ERR_OUT, TIMEOUT_OUT, JUNK_OUT, BYTE_RDY_OUT});
                        end
                        if (PKT_DATA_OUT !== 72'd0) begin
                            n_fail++;
                            $display("FAIL reset_data[%0d]: data=%h required 0", r.tag, PKT_DATA_OUT);
                        end
                    end
                    2: begin
                        n_tests++;
                        if (PKT_VLD_OUT !== 1'b1) begin
                            n_fail++;
                            $display("FAIL vld_latency[%0d]: PKT_VLD_OUT=%b required 1", r.tag, PKT_VLD_OUT);
                        end
                    end
                    default: begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL byte_stall[%0d]: byte not accepted within budget, required accept", r.tag);
                    end
                endcase
            end
        end
    end

    task automatic push_req(input int kind, input int tag);
        req_t r;
        r.kind   = kind;
        r.tag    = tag;
        r.e_csum = exp_csum;
        r.e_to   = exp_to;
        r.e_junk = exp_junk;
        req_q.push_back(r);
    endtask

    task automatic idle(input int n);
        BYTE_VLD_IN = 1'b0;
        repeat (n) begin
            @(posedge CLK_IN);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit done;
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        BYTE_DATA_IN = b;
        BYTE_VLD_IN  = 1'b1;
        n    = 0;
        done = 1'b0;
        while (!done && n < 500) begin
            @(negedge CLK_IN);
            done = (BYTE_RDY_OUT === 1'b1);
            @(posedge CLK_IN);
            #1;
            n++;
        end
        BYTE_VLD_IN = 1'b0;
        if (!done) push_req(3, int'(b));
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [31:0] k, input logic [31:0] p,
                              input logic [7:0] bad);
        if (bad == 8'd0) exp_q.push_back(model_pkt(c, k, p));
        else             exp_csum++;
        send_byte(8'h7E);
        send_byte(c);
        for (int i = 0; i < 4; i++) send_byte(k[8*i +: 8]);
        if (c[1]) for (int i = 0; i < 4; i++) send_byte(p[8*i +: 8]);
        send_byte(model_csum(c, k, p) ^ bad);
    endtask

    task automatic checkpoint(input int tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge CLK_IN);
            #1;
            n++;
        end
        idle(3);
        push_req(0, tag);
        idle(1);
    endtask

    initial begin
        logic [7:0]  c;
        logic [31:0] k;
        logic [31:0] p;
        logic [7:0]  j;
        int          nj;

        push_req(1, 0);
        idle(2);
        RESET_IN = 1'b0;
        idle(1);

        // Short packet, downstream always ready; valid must be up right after the checksum edge.
        send_frame(8'h00, 32'h12345678, 32'h0, 8'h00);
        push_req(2, 1);
        checkpoint(1);

        // Payload packet held for 10 cycles by backpressure.
        hold_low = 1'b1;
        idle(1);
        send_frame(8'h02, 32'hDDCCBBAA, 32'h44332211, 8'h00);
        push_req(2, 2);
        idle(10);
        hold_low = 1'b0;
        checkpoint(2);

        // Bad checksum (0x09) followed immediately by a good frame.
        send_frame(8'h00, 32'h12345678, 32'h0, 8'h01);
        send_frame(8'h02, 32'hDDCCBBAA, 32'h44332211, 8'h00);
        checkpoint(3);

        // Junk before SOF.
        send_byte(8'h11);
        send_byte(8'h22);
        exp_junk += 2;
        send_frame(8'h00, 32'h12345678, 32'h0, 8'h00);
        checkpoint(4);

        // Timeout after 8 idle cycles; a following non-SOF byte proves the return to HUNT.
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h78);
        idle(8);
        exp_to++;
        send_byte(8'h11);
        exp_junk++;
        checkpoint(5);

        // Next byte lands exactly in the expiry cycle: accepted, no timeout.
        exp_q.push_back(model_pkt(8'h00, 32'h12345678, 32'h0));
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h78);
        idle(7);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'h08);
        checkpoint(6);

        // SOF bytes inside a frame are plain data.
        send_frame(8'h7E, 32'h7E7E7E7E, 32'h0000007E, 8'h00);
        checkpoint(7);

        // Asynchronous reset while in KEY, then a fresh frame.
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        RESET_IN = 1'b1;
        push_req(1, 8);
        idle(2);
        RESET_IN = 1'b0;
        idle(1);
        send_frame(8'h00, 32'hCAFEF00D, 32'h0, 8'h00);
        checkpoint(8);

        // Randomised traffic: junk, gaps shorter than the timeout, random backpressure, bad checksums.
        rnd_bp  = 1'b1;
        gap_max = 4;
        for (int f = 0; f < 60; f++) begin
            nj = $urandom_range(0, 2);
            for (int i = 0; i < nj; i++) begin
                do j = 8'($urandom_range(0, 255)); while (j == 8'h7E);
                send_byte(j);
                exp_junk++;
            end
            c = 8'($urandom_range(0, 255));
            k = $urandom;
            p = $urandom;
            if ($urandom_range(0, 4) == 0) send_frame(c, k, p, 8'($urandom_range(1, 255)));
            else                           send_frame(c, k, p, 8'h00);
        end
        rnd_bp  = 1'b0;
        gap_max = 0;
        checkpoint(9);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
